wf_rgb_fb_write_arbiter: RTL and testbench
==========================================

// Module: wf_rgb_fb_write_arbiter
// PURPOSE
//  Shares the pixel-RAM write port (WF_bram256x16 wen/waddr/wdata) between two pixel writers, A and B.
//  Sits between the user logic and the frame memory read by WF_RGB_if.
//  Issues writes only inside the scan gap: the window opens after scan_done and closes on scan_en.
//  Frames are never torn mid-scan. Optional clear engine fills the whole frame with one colour.
// PARAMETERS
//  ADDR_W  6   pixel address width (64 pixels, one 8x8 matrix)
//  DATA_W  16  pixel word {1'b0,R[4:0],G[4:0],B[4:0]}
//  N_PIX   64  pixels swept by the clear engine (last addr = N_PIX-1)
// PORTS
//  clk          in   1       system clock (12 MHz SB_HFOSC)
//  reset        in   1       asynchronous, active-high reset
//  scan_en      in   1       WF_RGB_if scan start pulse (two_ms); closes window
//  scan_done    in   1       WF_RGB_if scan_done pulse; opens window
//  a_req/b_req  in   1       write request; hold with addr/data until grant
//  a_addr/b_addr in  ADDR_W  target pixel address
//  a_data/b_data in  DATA_W  pixel word
//  a_gnt/b_gnt  out  1       1-cycle pulse, coincident with the RAM write
//  clr_start    in   1       pulse: begin frame clear
//  clr_color    in   DATA_W  clear colour, sampled on clr_start
//  clr_busy     out  1       clear sequence in progress
//  clr_done     out  1       1-cycle pulse after last clear write
//  window       out  1       write window open
//  ram_wr_en    out  1       to BRAM wen
//  ram_wr_addr  out  ADDR_W  to BRAM waddr
//  ram_wr_pixels out DATA_W  to BRAM wdata
// BEHAVIOUR
//  - Reset: all outputs 0, window closed, RR pointer -> A, clear idle.
//  - Window FSM: CLOSED -> OPEN on scan_done. OPEN -> CLOSED on scan_en.
//    If both pulse in the same cycle, scan_en wins (window CLOSED).
//  - Decision in cycle N uses the req inputs and window state of cycle N.
//    Results are registered: ram_wr_*, *_gnt and clr progress appear in N+1.
//    The scan_en cycle itself grants nothing.
//  - Requester granted in cycle N (gnt seen in N+1) is masked in N+1, so a stale req is never rewritten.
//    The requester drops req or changes addr/data in N+2.
//    A lone requester therefore gets at most 1 write per 2 cycles; A and B together can alternate every cycle.
//  - Priority: clear engine (if busy) > A/B round-robin.
//    On A and B contention, grant the one not granted last; the pointer updates only on an A/B grant.
//  - ram_wr_addr/pixels hold their last value when ram_wr_en=0.
//  - Pending requests survive window close and are served in the next window. No request is dropped.
// CONFIGURATION
//  WF_FB_CLEAR_EN defined:
//    - clr_start latches clr_color and sets clr_busy next cycle; clear addr = 0.
//    - Each open-window cycle writes addr, then addr+1; A/B stall meanwhile.
//    - After the N_PIX-1 write: clr_busy=0 and clr_done=1 in the same cycle.
//    - clr_start while busy restarts at addr 0 with the new colour.
//    - A clear spans windows if needed.
//  WF_FB_CLEAR_EN undefined:
//    - clr_busy=0 and clr_done=0 constantly; clr_start and clr_color are ignored.
//    - Ports stay present.
// STRUCTURE
//  - Package wf_rgb_fb_pkg holds:
//      window state encoding (WIN_CLOSED, WIN_OPEN);
//      source ids (SRC_NONE, SRC_A, SRC_B, SRC_CLR);
//      localparams ADDR_W, DATA_W, N_PIX defaults.
//  - Sub-module wf_rgb_fb_clear_seq holds the colour latch, address counter and busy/done flags.
//    It is instantiated only under WF_FB_CLEAR_EN.
// TESTING
//  1. Reset mid-write: assert reset while ram_wr_en=1 -> all outputs 0 immediately.
//     After release, no grant until a scan_done.
//  2. Window gating: a_req=1, addr=5, data=16'h7C00 before scan_done -> no write.
//     scan_done at T -> a_gnt and ram_wr_en at T+2 with addr 5 and 16'h7C00.
//  3. Contention: a_req and b_req held in an open window -> grants A,B,A,B on consecutive cycles.
//     Each gnt is coincident with that source's addr/data.
//  4. Lone requester held: b_req held 6 cycles in window -> b_gnt every 2nd cycle, never back-to-back.
//  5. Close: scan_en and scan_done in the same cycle with req pending -> window=0, no gnt until the next scan_done.
//  6. (WF_FB_CLEAR_EN) clr_start, colour 16'h001F, a_req pending -> 64 writes addr 0..63 of 16'h001F.
//     clr_done with the addr-63 write. Then a_gnt. Also: clr_start at addr 30 -> restart at addr 0.

Source files
------------

// File: rtl/wf_rgb_fb_pkg.sv
// Shared constants for the pixel-RAM write arbiter: default geometry, window state
// encoding and the write-source ids used by the grant mux.
package wf_rgb_fb_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N_PIX  = 64;

    localparam logic WIN_CLOSED = 1'b0;
    localparam logic WIN_OPEN   = 1'b1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_CLR  = 2'd3
    } src_e;

endpackage

// File: rtl/wf_rgb_fb_write_arbiter_if.sv
// Writer / scan / RAM-port bundle for the pixel-RAM write arbiter.
// master = user logic side, slave = arbiter side.
interface wf_rgb_fb_write_arbiter_if #(
    parameter int unsigned ADDR_W = wf_rgb_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W = wf_rgb_fb_pkg::DATA_W
);
    import wf_rgb_fb_pkg::*;

    logic              scan_en;
    logic              scan_done;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_gnt;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_gnt;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              window;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_pixels;

    modport master (
        output scan_en, scan_done,
        output a_req, a_addr, a_data, b_req, b_addr, b_data, clr_start, clr_color,
        input  a_gnt, b_gnt, clr_busy, clr_done, window,
        input  ram_wr_en, ram_wr_addr, ram_wr_pixels
    );

    modport slave (
        input  scan_en, scan_done,
        input  a_req, a_addr, a_data, b_req, b_addr, b_data, clr_start, clr_color,
        output a_gnt, b_gnt, clr_busy, clr_done, window,
        output ram_wr_en, ram_wr_addr, ram_wr_pixels
    );

endinterface

// File: rtl/wf_rgb_fb_clear_seq.sv
// Frame clear sequencer: colour latch, sweep address counter and busy/done flags.
// step_i means "the current address is written this cycle"; start_i always restarts.
module wf_rgb_fb_clear_seq #(
    parameter int unsigned ADDR_W = wf_rgb_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W = wf_rgb_fb_pkg::DATA_W,
    parameter int unsigned N_PIX  = wf_rgb_fb_pkg::N_PIX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] color_i,
    input  logic              step_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] color_o
);
    import wf_rgb_fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] color_q, color_d;

    // Next-state: restart on start, otherwise advance on each performed write.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        color_d = color_q;
        if (start_i) begin
            busy_d  = 1'b1;
            addr_d  = '0;
            color_d = color_i;
        end else if (step_i) begin
            if (addr_q == LAST_ADDR) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                addr_d = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            color_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            color_q <= color_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign addr_o  = addr_q;
    assign color_o = color_q;

endmodule

// File: rtl/wf_rgb_fb_write_arbiter.sv
// Pixel-RAM write arbiter: shares the BRAM write port between writers A and B and
// only writes inside the scan gap (opened by scan_done, closed by scan_en).
// Optional frame clear engine is built when WF_FB_CLEAR_EN is defined.
module wf_rgb_fb_write_arbiter #(
    parameter int unsigned ADDR_W = wf_rgb_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W = wf_rgb_fb_pkg::DATA_W,
    parameter int unsigned N_PIX  = wf_rgb_fb_pkg::N_PIX
) (
    input logic                      clk,
    input logic                      reset,
    wf_rgb_fb_write_arbiter_if.slave bus
);
    import wf_rgb_fb_pkg::*;

    logic              win_q, win_d;
    logic              rr_b_q, rr_b_d;   // 1: B wins the next A/B contention
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    src_e              src;
    logic              can_write, a_ok, b_ok;
    logic              clr_busy, clr_done, clr_step;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_color;

    // The scan_en cycle is already outside the gap even though win_q still reads open.
    assign can_write = (win_q == WIN_OPEN) && !bus.scan_en;
    // A source granted last cycle still shows its old request; mask it.
    assign a_ok      = bus.a_req && !a_gnt_q;
    assign b_ok      = bus.b_req && !b_gnt_q;
    // A restart request suppresses the write of the old sweep in that cycle.
    assign clr_step  = can_write && clr_busy && !bus.clr_start;

`ifdef WF_FB_CLEAR_EN
    wf_rgb_fb_clear_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_PIX  (N_PIX)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .start_i (bus.clr_start),
        .color_i (bus.clr_color),
        .step_i  (clr_step),
        .busy_o  (clr_busy),
        .done_o  (clr_done),
        .addr_o  (clr_addr),
        .color_o (clr_color)
    );
`else
    localparam int unsigned unused_n_pix = N_PIX;
    logic unused_clr;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign clr_addr   = '0;
    assign clr_color  = '0;
    assign unused_clr = ^{bus.clr_start, bus.clr_color, clr_step};
`endif

    // Window FSM: scan_en dominates scan_done.
    always_comb begin
        win_d = win_q;
        if (bus.scan_en) begin
            win_d = WIN_CLOSED;
        end else if (bus.scan_done) begin
            win_d = WIN_OPEN;
        end
    end

    // Source selection: clear engine owns the port while busy, else round-robin A/B.
    always_comb begin
        src = SRC_NONE;
        if (can_write) begin
            if (clr_busy) begin
                if (clr_step) begin
                    src = SRC_CLR;
                end
            end else if (a_ok && b_ok) begin
                src = rr_b_q ? SRC_B : SRC_A;
            end else if (a_ok) begin
                src = SRC_A;
            end else if (b_ok) begin
                src = SRC_B;
            end
        end
    end

    // Registered RAM write, grants and round-robin pointer; address/data hold when idle.
    always_comb begin
        wr_en_d   = 1'b0;
        a_gnt_d   = 1'b0;
        b_gnt_d   = 1'b0;
        rr_b_d    = rr_b_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (src)
            SRC_A: begin
                wr_en_d   = 1'b1;
                a_gnt_d   = 1'b1;
                rr_b_d    = 1'b1;
                wr_addr_d = bus.a_addr;
                wr_data_d = bus.a_data;
            end
            SRC_B: begin
                wr_en_d   = 1'b1;
                b_gnt_d   = 1'b1;
                rr_b_d    = 1'b0;
                wr_addr_d = bus.b_addr;
                wr_data_d = bus.b_data;
            end
            SRC_CLR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_addr;
                wr_data_d = clr_color;
            end
            default: ;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q     <= WIN_CLOSED;
            rr_b_q    <= 1'b0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            win_q     <= win_d;
            rr_b_q    <= rr_b_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.window        = win_q;
    assign bus.a_gnt         = a_gnt_q;
    assign bus.b_gnt         = b_gnt_q;
    assign bus.ram_wr_en     = wr_en_q;
    assign bus.ram_wr_addr   = wr_addr_q;
    assign bus.ram_wr_pixels = wr_data_q;
    assign bus.clr_busy      = clr_busy;
    assign bus.clr_done      = clr_done;

endmodule

// File: tb/tb_wf_rgb_fb_write_arbiter.sv
// Scoreboard bench for wf_rgb_fb_write_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model. Honours WF_FB_CLEAR_EN.
module tb_wf_rgb_fb_write_arbiter;

    localparam int N_PIX = 64;

    typedef struct {
        int          cyc;
        logic        a;
        logic        b;
        logic        done;
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic win;
        logic busy;
    } st_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_on = 1'b0;

    wr_t  wr_q[$];
    st_t  st_q[$];

    // reference model state
    bit          m_open;
    bit          m_last_b;
    bit          m_a_stale, m_b_stale;
    int          m_clr_left;
    logic [15:0] m_clr_col;
    int          a_gcyc, b_gcyc;
    int          a_rate, b_rate;
    logic [5:0]  exp_addr;
    logic [15:0] exp_data;
    wr_t         mon_w;
    st_t         mon_s;

    wf_rgb_fb_write_arbiter_if bus ();

    wf_rgb_fb_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_open     = 1'b0;
        m_last_b   = 1'b1;
        m_a_stale  = 1'b0;
        m_b_stale  = 1'b0;
        m_clr_left = 0;
        m_clr_col  = '0;
        exp_addr   = '0;
        exp_data   = '0;
    endfunction

    // One decision cycle of the reference model, pushing what must appear next cycle.
    task automatic model_step(input bit se, input bit sd, input bit cs, input logic [15:0] cc);
        int  src;
        bit  a_el, b_el;
        wr_t w;
        st_t s;
        src    = 0;
        w.done = 1'b0;
        w.addr = '0;
        w.data = '0;
        if (m_open && !se) begin
            if (m_clr_left > 0) begin
                if (!cs) begin
                    src    = 3;
                    w.addr = 6'(N_PIX - m_clr_left);
                    w.data = m_clr_col;
                    m_clr_left--;
                    w.done = (m_clr_left == 0);
                end
            end else begin
                a_el = bus.a_req && !m_a_stale;
                b_el = bus.b_req && !m_b_stale;
                if (a_el && b_el) src = m_last_b ? 1 : 2;
                else if (a_el) src = 1;
                else if (b_el) src = 2;
            end
        end
        m_a_stale = (src == 1);
        m_b_stale = (src == 2);
        if (src == 1) begin
            m_last_b = 1'b0;
            a_gcyc   = cyc;
            w.addr   = bus.a_addr;
            w.data   = bus.a_data;
        end
        if (src == 2) begin
            m_last_b = 1'b1;
            b_gcyc   = cyc;
            w.addr   = bus.b_addr;
            w.data   = bus.b_data;
        end
        if (se) m_open = 1'b0;
        else if (sd) m_open = 1'b1;
`ifdef WF_FB_CLEAR_EN
        if (cs) begin
            m_clr_left = N_PIX;
            m_clr_col  = cc;
        end
`endif
        s.win  = m_open;
        s.busy = (m_clr_left > 0);
        st_q.push_back(s);
        if (src != 0) begin
            w.cyc = cyc + 1;
            w.a   = (src == 1);
            w.b   = (src == 2);
            wr_q.push_back(w);
        end
    endtask

    // Requesters: hold until granted, keep the stale request one more cycle, then renew.
    task automatic agents();
        if (bus.a_req && a_gcyc == cyc - 2) bus.a_req = 1'b0;
        if (!bus.a_req && $urandom_range(99) < a_rate) begin
            bus.a_req  = 1'b1;
            bus.a_addr = 6'($urandom);
            bus.a_data = {1'b0, 15'($urandom)};
        end
        if (bus.b_req && b_gcyc == cyc - 2) bus.b_req = 1'b0;
        if (!bus.b_req && $urandom_range(99) < b_rate) begin
            bus.b_req  = 1'b1;
            bus.b_addr = 6'($urandom);
            bus.b_data = {1'b0, 15'($urandom)};
        end
    endtask

    // Entered and left at posedge + 1.
    task automatic step(input bit se, input bit sd, input bit cs, input logic [15:0] cc);
        agents();
        bus.scan_en   = se;
        bus.scan_done = sd;
        bus.clr_start = cs;
        bus.clr_color = cc;
        model_step(se, sd, cs, cc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic drain();
        a_rate = 0;
        b_rate = 0;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(150);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(3);
    endtask

    // Monitor: per-cycle state plus every presented write popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_on && !reset) begin
            if (st_q.size() == 0) begin
                chk("state_entry", st_q.size(), 1);
            end else begin
                mon_s = st_q.pop_front();
                chk("window", bus.window, mon_s.win);
                chk("clr_busy", bus.clr_busy, mon_s.busy);
            end
            if (bus.ram_wr_en || bus.a_gnt || bus.b_gnt || bus.clr_done) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {bus.ram_wr_en, bus.a_gnt, bus.b_gnt, bus.clr_done}, 0);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_cycle", cyc, mon_w.cyc);
                    chk("wr_flags", {bus.ram_wr_en, bus.a_gnt, bus.b_gnt, bus.clr_done},
                        {1'b1, mon_w.a, mon_w.b, mon_w.done});
                    chk("wr_addr", bus.ram_wr_addr, mon_w.addr);
                    chk("wr_pixels", bus.ram_wr_pixels, mon_w.data);
                    exp_addr = mon_w.addr;
                    exp_data = mon_w.data;
                end
            end else begin
                if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
                    chk("missing_write", bus.ram_wr_en, 1);
                    void'(wr_q.pop_front());
                end
                chk("hold_addr", bus.ram_wr_addr, exp_addr);
                chk("hold_pixels", bus.ram_wr_pixels, exp_data);
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return {4'b0, bus.a_gnt, bus.b_gnt, bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_pixels,
                bus.window, bus.clr_busy, bus.clr_done};
    endfunction

    initial begin
        bit found;
        logic [15:0] col;
        bus.scan_en   = 1'b0;
        bus.scan_done = 1'b0;
        bus.a_req     = 1'b0;
        bus.a_addr    = '0;
        bus.a_data    = '0;
        bus.b_req     = 1'b0;
        bus.b_addr    = '0;
        bus.b_data    = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
        a_gcyc = -100;
        b_gcyc = -100;
        a_rate = 0;
        b_rate = 0;
        model_reset();

        #12;
        chk("reset_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        st_q.push_back('{win: 1'b0, busy: 1'b0});
        mon_on = 1'b1;

        // window gating: request before scan_done must wait, then lands at T+2
        bus.a_req  = 1'b1;
        bus.a_addr = 6'd5;
        bus.a_data = 16'h7C00;
        idle(4);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 16'h0);

        // contention A/B alternation, then simultaneous scan_en/scan_done close
        a_rate = 100;
        b_rate = 100;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(10);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        drain();

        // lone requester held
        b_rate = 100;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(8);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        drain();

        // frame clear with a pending A request, then restart mid-sweep
        bus.a_req  = 1'b1;
        bus.a_addr = 6'd9;
        bus.a_data = 16'h1234;
        step(1'b0, 1'b0, 1'b1, 16'h001F);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(70);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        col = {1'b0, 15'($urandom)};
        step(1'b0, 1'b0, 1'b1, col);
        step(1'b0, 1'b1, 1'b0, 16'h0);
`ifdef WF_FB_CLEAR_EN
        for (int g = 0; g < 100 && m_clr_left != N_PIX - 30; g++) idle(1);
`endif
        col = {1'b0, 15'($urandom)};
        step(1'b0, 1'b0, 1'b1, col);
        idle(70);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        drain();

        // random traffic, windows and clears
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                a_rate = $urandom_range(100);
                b_rate = $urandom_range(100);
            end
            step($urandom_range(99) < 4, $urandom_range(99) < 6, $urandom_range(199) == 0,
                 {1'b0, 15'($urandom)});
        end

        // asynchronous reset while a write is on the port
        a_rate = 100;
        b_rate = 100;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.ram_wr_en) found = 1'b1;
            else idle(1);
        end
        chk("write_before_reset", bus.ram_wr_en, 1);
        reset = 1'b1;
        #1;
        chk("reset_async", all_outputs(), 0);
        @(posedge clk);
        #1;
        st_q.delete();
        wr_q.delete();
        model_reset();
        st_q.push_back('{win: 1'b0, busy: 1'b0});
        reset = 1'b0;
        idle(5);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        idle(10);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        a_rate = 0;
        b_rate = 0;
        idle(3);

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        chk("scoreboard_drained", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
